// File: rtl/simple_proc_data_proc.sv
// simple_proc_data_proc: two-cycle FETCH/EXEC 16-bit processor with an 8x16 register file and a 32x16 data RAM.
// Ports: clk, rst_n (async active-low); start (level enable out of IDLE); data_in (instruction word,
// valid the cycle after ram_read_en); pc (program RAM address); ram_read_en (fetch strobe);
// result (last register-file write value); zero/negative/overflow/carry (ALU flags Z/N/V/C).
// Optional feature: define SIMPLE_PROC_MUL_EN to enable opcode 0x10 = MUL; otherwise 0x10 is a NOP.

module reg_file_8x16_1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [2:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [2:0]  raddr_a_i,
    input  logic [2:0]  raddr_b_i,
    output logic [15:0] rdata_a_o,
    output logic [15:0] rdata_b_o
);
    logic [15:0] rf_q [8];
    assign rdata_a_o = rf_q[raddr_a_i];
    assign rdata_b_o = rf_q[raddr_b_i];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end
endmodule

module ram_rw (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o
);
    logic [15:0] ram_data [32];
    assign rdata_o = ram_data[addr_i];
    always_ff @(posedge clk) begin
        if (we_i) ram_data[addr_i] <= wdata_i;
    end
endmodule

module simple_proc_data_proc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [9:0]  pc,
    output logic        ram_read_en,
    output logic [15:0] result,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        carry
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    state_t      state_q;
    logic [9:0]  pc_q, pc_d;
    logic        ren_q, z_q, n_q, v_q, c_q;
    logic [15:0] result_q;
    logic [5:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] imm, rs_val, rt_val, dm_rdata, wr_val;
    logic [16:0] add, sub;
    logic        exec, wr_en, dm_we, c_d, v_d;

    assign op   = data_in[15:10];
    assign rd   = data_in[9:7];
    assign rs   = data_in[6:4];
    assign rt   = data_in[3:1];
    assign imm  = {{9{data_in[6]}}, data_in[6:0]};
    assign exec = state_q == EXEC;
    assign add  = {1'b0, rs_val} + {1'b0, rt_val};
    assign sub  = {1'b0, rs_val} - {1'b0, rt_val};

    reg_file_8x16_1 u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (exec && wr_en),
        .waddr_i   (rd),
        .wdata_i   (wr_val),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_val),
        .rdata_b_o (rt_val)
    );

    ram_rw u_dmem (
        .clk     (clk),
        .we_i    (exec && dm_we),
        .addr_i  (rs_val[4:0]),
        .wdata_i (rt_val),
        .rdata_o (dm_rdata)
    );

    always_comb begin
        wr_en  = 1'b0;
        wr_val = '0;
        dm_we  = 1'b0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        case (op)
            6'h01: begin wr_en = 1'b1; wr_val = add[15:0]; c_d = add[16];
                   v_d = (rs_val[15] == rt_val[15]) && (add[15] != rs_val[15]); end
            // Borrow out of the 17-bit difference is exactly rs < rt unsigned.
            6'h02: begin wr_en = 1'b1; wr_val = sub[15:0]; c_d = sub[16];
                   v_d = (rs_val[15] != rt_val[15]) && (sub[15] != rs_val[15]); end
            6'h03: begin wr_en = 1'b1; wr_val = rs_val & rt_val; end
            6'h04: begin wr_en = 1'b1; wr_val = rs_val | rt_val; end
            6'h05: begin wr_en = 1'b1; wr_val = rs_val ^ rt_val; end
            6'h06: begin wr_en = 1'b1; wr_val = ~rs_val; end
            6'h07: begin wr_en = 1'b1; wr_val = {rs_val[14:0], 1'b0}; c_d = rs_val[15]; end
            6'h08: begin wr_en = 1'b1; wr_val = {1'b0, rs_val[15:1]}; c_d = rs_val[0]; end
            6'h09: begin wr_en = 1'b1; wr_val = imm; end
            6'h0A: begin wr_en = 1'b1; wr_val = dm_rdata; end
            6'h0B: dm_we = 1'b1;
`ifdef SIMPLE_PROC_MUL_EN
            6'h10: begin wr_en = 1'b1; wr_val = rs_val * rt_val; end
`endif
            default: ;
        endcase
    end

    // Branches test the flags as they stood before this instruction.
    assign pc_d = (op == 6'h0C || (op == 6'h0D && z_q) || (op == 6'h0E && n_q)) ? data_in[9:0] :
                  (op == 6'h0F) ? pc_q : pc_q + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ren_q    <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= FETCH;
                    ren_q   <= 1'b1;
                end
                FETCH: begin
                    state_q <= EXEC;
                    ren_q   <= 1'b0;
                end
                EXEC: begin
                    state_q <= (op == 6'h0F) ? HALT : FETCH;
                    ren_q   <= op != 6'h0F;
                    pc_q    <= pc_d;
                    if (wr_en) begin
                        result_q <= wr_val;
                        z_q      <= wr_val == 16'h0;
                        n_q      <= wr_val[15];
                        c_q      <= c_d;
                        v_q      <= v_d;
                    end
                end
                HALT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc          = pc_q;
    assign ram_read_en = ren_q;
    assign result      = result_q;
    assign zero        = z_q;
    assign negative    = n_q;
    assign overflow    = v_q;
    assign carry       = c_q;
endmodule

// File: tb/tb_simple_proc_data_proc.sv
// tb_simple_proc_data_proc: directed-program bench for simple_proc_data_proc with a behavioural program RAM.
module tb_simple_proc_data_proc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [9:0]  pc;
    logic        ram_read_en;
    logic [15:0] result;
    logic        zero, negative, overflow, carry;
    logic [15:0] prog [1024];
    int          n_checks = 0;
    int          n_errors = 0;

    simple_proc_data_proc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .pc          (pc),
        .ram_read_en (ram_read_en),
        .result      (result),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .carry       (carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_read_en) data_in <= prog[pc];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (2 * n) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_prog();
        #12;
        check("rst_pc", pc, 16'h0);
        check("rst_result", result, 16'h0);
        check("rst_flags", {zero, negative, carry, overflow}, 16'h0);
        check("rst_ren", ram_read_en, 16'h0);

        prog[0] = 16'h2485; prog[1] = 16'h2503; prog[2] = 16'h0594; prog[3] = 16'h3C00;
        reset_dut();
        step(2);
        check("idle_pc", pc, 16'h0);
        check("idle_ren", ram_read_en, 16'h0);
        go();
        check("fetch_ren", ram_read_en, 16'h1);
        step(4);
        check("p1_r1", dut.u_rf.rf_q[1], 16'h0005);
        check("p1_r2", dut.u_rf.rf_q[2], 16'h0003);
        check("p1_r3", dut.u_rf.rf_q[3], 16'h0008);
        check("p1_result", result, 16'h0008);
        check("p1_flags", {zero, negative, carry, overflow}, 16'h0);
        check("p1_pc", pc, 16'h3);
        step(3);
        check("halt_pc", pc, 16'h3);
        check("halt_ren", ram_read_en, 16'h0);

        clear_prog();
        prog[0] = 16'h2480; prog[1] = 16'h2501; prog[2] = 16'h0994; prog[3] = 16'h380A; prog[10] = 16'h3C00;
        reset_dut();
        go();
        step(3);
        check("sub_r3", dut.u_rf.rf_q[3], 16'hFFFF);
        check("sub_result", result, 16'hFFFF);
        check("sub_flags", {zero, negative, carry, overflow}, 16'b0110);
        step(1);
        check("bn_pc", pc, 16'd10);
        step(1);
        check("halt2_pc", pc, 16'd10);
        check("halt2_flags", {zero, negative, carry, overflow}, 16'b0110);

        clear_prog();
        prog[0] = 16'h24FF; prog[1] = 16'h0492; prog[2] = 16'h2210; prog[3] = 16'h1692; prog[4] = 16'h3C00;
        reset_dut();
        go();
        step(1);
        check("ldi_neg", result, 16'hFFFF);
        check("ldi_flags", {zero, negative, carry, overflow}, 16'b0100);
        step(1);
        check("add_self_r1", dut.u_rf.rf_q[1], 16'hFFFE);
        check("add_flags", {zero, negative, carry, overflow}, 16'b0110);
        step(1);
        check("shr_r4", dut.u_rf.rf_q[4], 16'h7FFF);
        check("shr_flags", {zero, negative, carry, overflow}, 16'b0000);
        step(1);
        check("xor_r5", dut.u_rf.rf_q[5], 16'h0000);
        check("xor_flags", {zero, negative, carry, overflow}, 16'b1000);

        clear_prog();
        prog[0] = 16'h2484; prog[1] = 16'h2507; prog[2] = 16'h2C14; prog[3] = 16'h2990; prog[4] = 16'h3C00;
        reset_dut();
        go();
        step(3);
        check("st_mem4", dut.u_dmem.ram_data[4], 16'h0007);
        check("st_result", result, 16'h0007);
        step(1);
        check("ld_r3", dut.u_rf.rf_q[3], 16'h0007);
        check("ld_flags", {zero, negative, carry, overflow}, 16'b0000);

        clear_prog();
        prog[0] = 16'h2480; prog[1] = 16'h3405; prog[5] = 16'h2501; prog[6] = 16'h3400;
        prog[7] = 16'h33FF; prog[1023] = 16'h0000;
        reset_dut();
        go();
        step(1);
        check("br_pc1", pc, 16'd1);
        check("br_z", {zero, negative, carry, overflow}, 16'b1000);
        step(1);
        check("bz_taken", pc, 16'd5);
        step(1);
        check("br_pc6", pc, 16'd6);
        step(1);
        check("bz_not_taken", pc, 16'd7);
        step(1);
        check("jmp_pc", pc, 16'h3FF);
        step(1);
        check("pc_wrap", pc, 16'h0);
        check("nop_result", result, 16'h0001);

        clear_prog();
        prog[0] = 16'h2485; prog[1] = 16'h2503; prog[2] = 16'h0594; prog[3] = 16'h3C00;
        reset_dut();
        go();
        step(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_r1", dut.u_rf.rf_q[1], 16'h0);
        check("abort_r2", dut.u_rf.rf_q[2], 16'h0);
        check("abort_r3", dut.u_rf.rf_q[3], 16'h0);
        check("abort_pc", pc, 16'h0);
        check("abort_result", result, 16'h0);
        check("abort_flags", {zero, negative, carry, overflow}, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        go();
        step(1);
        check("restart_pc", pc, 16'd1);
        check("restart_r1", dut.u_rf.rf_q[1], 16'h0005);

        clear_prog();
        prog[0] = 16'h2483; prog[1] = 16'h2504; prog[2] = 16'h4194; prog[3] = 16'h3C00;
        reset_dut();
        go();
        step(3);
`ifdef SIMPLE_PROC_MUL_EN
        check("mul_r3", dut.u_rf.rf_q[3], 16'd12);
        check("mul_result", result, 16'd12);
`else
        check("mul_r3", dut.u_rf.rf_q[3], 16'd0);
        check("mul_result", result, 16'd4);
`endif
        check("mul_flags", {zero, negative, carry, overflow}, 16'b0000);
        check("mul_pc", pc, 16'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
